offset_cal_ctrl: RTL and testbench
==================================

Name: offset_cal_ctrl

Overview:
Calibration sequencer and offset corrector placed directly after the datapath channel output. On request it forces the front end into calibration mode (differential VCO inputs shorted) and discards settling samples. It then averages a power-of-two block of channel samples, stores the mean as the channel offset, and returns to normal mode. In normal mode it subtracts the stored offset from every sample, with saturation, and forwards the result downstream.

Parameters:
W_IN, 9, width of the signed channel sample (datapath channel_output width).
LOG2_N, 8, log2 of the number of samples averaged; 1..12.
SETTLE_SAMPLES, 16, samples discarded after cal_mode asserts; 0..65535.

Ports:
CLK_24M  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous reset, active-high.
cal_start  input  1  one-cycle pulse requesting a calibration run.
data_in  input  W_IN  signed sample from the datapath.
data_valid  input  1  one-cycle strobe marking a new data_in (one per CLK_3M period).
data_out  output  W_IN  signed corrected sample.
data_out_valid  output  1  one-cycle strobe for data_out.
cal_mode  output  1  high while the front-end inputs must be shorted.
busy  output  1  high in SETTLE, ACCUM and APPLY.
cal_done  output  1  high after a successful calibration until the next cal_start or reset.
offset  output  W_IN  currently applied offset, signed.

Behaviour:
- Reset (sampled on a CLK_24M edge with reset=1) forces:
  - state=IDLE, offset=0, data_out=0, data_out_valid=0, cal_mode=0, busy=0, cal_done=0.
  - Settle counter and sample counter cleared; accumulator cleared.
  - Reset has priority over every other input, including mid-calibration.
- States: IDLE, SETTLE, ACCUM, APPLY, RUN.
- IDLE and RUN (pass-through states):
  - Each data_valid produces data_out=sat(data_in - offset) and data_out_valid=1 on the next edge (1-cycle latency).
  - IDLE is the post-reset state; it behaves exactly like RUN with offset=0.
- cal_start in IDLE or RUN:
  - Next state is SETTLE; clears the settle counter, sample counter, accumulator and cal_done.
  - A data_valid in the same cycle as cal_start is still corrected and output under the old state and offset.
- SETTLE:
  - cal_mode=1, busy=1, no data_out_valid.
  - Counts data_valid pulses; after SETTLE_SAMPLES pulses, moves to ACCUM.
  - With SETTLE_SAMPLES=0, moves to ACCUM on the next edge.
- ACCUM:
  - cal_mode=1, busy=1, no data_out_valid.
  - Each data_valid adds sign-extended data_in into a signed accumulator of W_IN+LOG2_N bits; overflow is impossible at this width.
  - After 2^LOG2_N samples, moves to APPLY.
- APPLY (exactly one cycle):
  - offset <= acc >>> LOG2_N (arithmetic shift, i.e. floor toward -inf).
  - cal_done <= 1, cal_mode <= 0, next state RUN.
  - A data_valid arriving in APPLY is dropped and produces no output.
- cal_start during SETTLE or ACCUM:
  - Restarts calibration: state=SETTLE, counters and accumulator cleared.
  - offset keeps its previous value.
- cal_start during APPLY: APPLY completes first, then the request is treated as a RUN-state cal_start on the following cycle.
- Arithmetic: the difference data_in - offset is computed at W_IN+1 bits, then saturated to [-2^(W_IN-1), 2^(W_IN-1)-1] (for W_IN=9, [-256, 255]).
- cal_mode and busy are registered outputs that change on the edge that enters or leaves a state.
- Counters never wrap; they stop at their terminal count.

Test Plan:
1. Reset check: reset=1 for 3 cycles -> all outputs 0. Then data_valid with data_in=-7 -> data_out=-7, data_out_valid high exactly 1 cycle later.
2. Basic calibration (LOG2_N=4, SETTLE_SAMPLES=2): cal_start, then constant data_in=+5 at 1/8 clock rate.
   - cal_mode rises 1 cycle after cal_start; 2 samples discarded; 16 samples accumulated; APPLY; offset=5; cal_done=1.
   - No data_out_valid is produced while busy.
   - Afterwards data_in=5 -> data_out=0.
3. Floor rounding: alternate -3/-2 during ACCUM (LOG2_N=4) -> acc=-40, offset=-3.
   - Afterwards data_in=250 -> data_out=253; data_in=253 -> data_out=255 (saturates from 256).
4. Negative saturation: offset=+10 (after calibrating on +10) -> data_in=-256 gives data_out=-256; data_in=-250 gives data_out=-256.
5. Restart and reset mid-run:
   - cal_start at ACCUM sample 9 -> re-enters SETTLE; offset keeps its old value; the full count restarts.
   - reset asserted mid-ACCUM -> IDLE, offset=0, cal_mode=0 on the next edge.
6. Simultaneous events: cal_start and data_valid in the same RUN cycle -> that sample is output once with the old offset, and state=SETTLE on the next edge.

Source files
------------

// File: rtl/offset_cal_ctrl.sv
// Calibration sequencer and saturating offset corrector for one datapath channel.
// Averages 2^LOG2_N samples with the front end shorted and subtracts the mean in normal mode.
module offset_cal_ctrl #(
  parameter int unsigned W_IN           = 9,
  parameter int unsigned LOG2_N         = 8,
  parameter int unsigned SETTLE_SAMPLES = 16
) (
  input  logic                   CLK_24M,
  input  logic                   reset,
  input  logic                   cal_start,
  input  logic signed [W_IN-1:0] data_in,
  input  logic                   data_valid,
  output logic signed [W_IN-1:0] data_out,
  output logic                   data_out_valid,
  output logic                   cal_mode,
  output logic                   busy,
  output logic                   cal_done,
  output logic signed [W_IN-1:0] offset
);

  localparam int unsigned AccW = W_IN + LOG2_N;

  localparam logic [15:0]       SettleLast = 16'(SETTLE_SAMPLES - 1);
  localparam logic [LOG2_N-1:0] SampLast   = '1;

  localparam logic signed [W_IN:0] SatMax = {2'b00, {(W_IN-1){1'b1}}};
  localparam logic signed [W_IN:0] SatMin = {2'b11, {(W_IN-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StAccum,
    StApply,
    StRun
  } state_e;

  state_e                   state_q, state_d;
  logic [15:0]              settle_cnt_q, settle_cnt_d;
  logic [LOG2_N-1:0]        samp_cnt_q, samp_cnt_d;
  logic signed [AccW-1:0]   acc_q, acc_d;
  logic signed [W_IN-1:0]   offset_q, offset_d;
  logic signed [W_IN-1:0]   data_out_q, data_out_d;
  logic                     data_out_valid_q, data_out_valid_d;
  logic                     cal_mode_q, cal_mode_d;
  logic                     busy_q, busy_d;
  logic                     cal_done_q, cal_done_d;
  // cal_start seen in APPLY, replayed as a RUN-state request on the next cycle
  logic                     pend_q, pend_d;

  logic signed [W_IN:0]     diff;
  logic signed [W_IN-1:0]   diff_sat;
  logic signed [AccW-1:0]   data_ext;
  logic signed [AccW-1:0]   acc_mean;

  assign diff     = {data_in[W_IN-1], data_in} - {offset_q[W_IN-1], offset_q};
  assign data_ext = {{LOG2_N{data_in[W_IN-1]}}, data_in};
  // Arithmetic shift floors toward -inf; the mean of W_IN-bit samples fits in W_IN bits.
  assign acc_mean = acc_q >>> LOG2_N;

  always_comb begin
    if (diff > SatMax) begin
      diff_sat = SatMax[W_IN-1:0];
    end else if (diff < SatMin) begin
      diff_sat = SatMin[W_IN-1:0];
    end else begin
      diff_sat = diff[W_IN-1:0];
    end
  end

  always_comb begin
    state_d          = state_q;
    settle_cnt_d     = settle_cnt_q;
    samp_cnt_d       = samp_cnt_q;
    acc_d            = acc_q;
    offset_d         = offset_q;
    data_out_d       = data_out_q;
    data_out_valid_d = 1'b0;
    cal_done_d       = cal_done_q;
    pend_d           = pend_q;

    unique case (state_q)
      StIdle, StRun: begin
        if (data_valid) begin
          data_out_d       = diff_sat;
          data_out_valid_d = 1'b1;
        end
        if (cal_start || pend_q) begin
          state_d      = StSettle;
          settle_cnt_d = '0;
          samp_cnt_d   = '0;
          acc_d        = '0;
          cal_done_d   = 1'b0;
          pend_d       = 1'b0;
        end
      end
      StSettle: begin
        if (cal_start) begin
          settle_cnt_d = '0;
          samp_cnt_d   = '0;
          acc_d        = '0;
        end else if (SETTLE_SAMPLES == 0) begin
          state_d = StAccum;
        end else if (data_valid) begin
          if (settle_cnt_q == SettleLast) begin
            state_d = StAccum;
          end else begin
            settle_cnt_d = settle_cnt_q + 16'd1;
          end
        end
      end
      StAccum: begin
        if (cal_start) begin
          state_d      = StSettle;
          settle_cnt_d = '0;
          samp_cnt_d   = '0;
          acc_d        = '0;
        end else if (data_valid) begin
          acc_d = acc_q + data_ext;
          if (samp_cnt_q == SampLast) begin
            state_d = StApply;
          end else begin
            samp_cnt_d = samp_cnt_q + 1'b1;
          end
        end
      end
      StApply: begin
        offset_d   = acc_mean[W_IN-1:0];
        cal_done_d = 1'b1;
        state_d    = StRun;
        if (cal_start) begin
          pend_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Front end stays shorted until the edge that leaves APPLY.
    cal_mode_d = (state_d == StSettle) || (state_d == StAccum) || (state_d == StApply);
    busy_d     = (state_d == StSettle) || (state_d == StAccum) || (state_d == StApply);
  end

  always_ff @(posedge CLK_24M) begin
    if (reset) begin
      state_q          <= StIdle;
      settle_cnt_q     <= '0;
      samp_cnt_q       <= '0;
      acc_q            <= '0;
      offset_q         <= '0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      cal_mode_q       <= 1'b0;
      busy_q           <= 1'b0;
      cal_done_q       <= 1'b0;
      pend_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      settle_cnt_q     <= settle_cnt_d;
      samp_cnt_q       <= samp_cnt_d;
      acc_q            <= acc_d;
      offset_q         <= offset_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      cal_mode_q       <= cal_mode_d;
      busy_q           <= busy_d;
      cal_done_q       <= cal_done_d;
      pend_q           <= pend_d;
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;
  assign cal_mode       = cal_mode_q;
  assign busy           = busy_q;
  assign cal_done       = cal_done_q;
  assign offset         = offset_q;

endmodule

// File: tb/tb_offset_cal_ctrl.sv
// Randomized bench for offset_cal_ctrl against a sample-level model of the calibration rules.
module tb_offset_cal_ctrl;

  localparam int WIn    = 9;
  localparam int Log2N  = 4;
  localparam int Settle = 2;
  localparam int NS     = 1 << Log2N;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  cal_start;
  logic signed [WIn-1:0] data_in;
  logic                  data_valid;
  logic signed [WIn-1:0] data_out;
  logic                  data_out_valid;
  logic                  cal_mode;
  logic                  busy;
  logic                  cal_done;
  logic signed [WIn-1:0] offset;

  int n_vec   = 0;
  int n_err   = 0;
  int exp_off = 0;

  always #5 clk = ~clk;

  offset_cal_ctrl #(
    .W_IN          (WIn),
    .LOG2_N        (Log2N),
    .SETTLE_SAMPLES(Settle)
  ) dut (
    .CLK_24M       (clk),
    .reset         (reset),
    .cal_start     (cal_start),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .cal_mode      (cal_mode),
    .busy          (busy),
    .cal_done      (cal_done),
    .offset        (offset)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_ref(input int x, input int off);
    int d = x - off;
    if (d > 255) return 255;
    if (d < -256) return -256;
    return d;
  endfunction

  function automatic int floor_mean(input int sum);
    int q = sum / NS;
    if ((sum % NS) != 0 && sum < 0) q = q - 1;
    return q;
  endfunction

  function automatic int rnd_sample();
    return int'($urandom_range(511)) - 256;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      data_in = WIn'($urandom);
      step();
      check(tag, int'(data_out_valid), 0);
    end
  endtask

  // Pass-through sample: 1-cycle latency, single-cycle strobe.
  task automatic pass(input int x);
    data_in    = WIn'(x);
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    check("pass_valid", int'(data_out_valid), 1);
    check("pass_data", int'(data_out), sat_ref(x, exp_off));
    idle(1 + int'($urandom_range(2)), "pass_strobe");
  endtask

  task automatic start_cal();
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
    check("start_calmode", int'(cal_mode), 1);
    check("start_busy", int'(busy), 1);
    check("start_done", int'(cal_done), 0);
  endtask

  // One sample while calibrating: random idle gap, then the strobe; never any output.
  task automatic send_cal(input int x);
    int gap = int'($urandom_range(3));
    for (int i = 0; i < gap; i++) begin
      data_in = WIn'($urandom);
      step();
      check("cal_gap_valid", int'(data_out_valid), 0);
      check("cal_gap_mode", int'(cal_mode), 1);
    end
    data_in    = WIn'(x);
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    check("cal_valid", int'(data_out_valid), 0);
    check("cal_busy", int'(busy), 1);
  endtask

  // Settling discards, then NS averaged samples; ends one cycle into RUN.
  task automatic feed_cal(input int vals[NS], input bit start_in_apply);
    int sum = 0;
    for (int i = 0; i < Settle; i++) send_cal(rnd_sample());
    for (int i = 0; i < NS; i++) begin
      send_cal(vals[i]);
      sum += vals[i];
    end
    check("apply_done", int'(cal_done), 0);
    if (start_in_apply) begin
      cal_start  = 1'b1;
      data_valid = 1'b1;
      data_in    = WIn'(rnd_sample());
    end
    step();
    cal_start  = 1'b0;
    data_valid = 1'b0;
    exp_off    = floor_mean(sum);
    check("run_offset", int'(offset), exp_off);
    check("run_done", int'(cal_done), 1);
    check("run_busy", int'(busy), 0);
    check("run_calmode", int'(cal_mode), 0);
    check("run_valid", int'(data_out_valid), 0);
    if (start_in_apply) begin
      step();
      check("replay_calmode", int'(cal_mode), 1);
      check("replay_busy", int'(busy), 1);
      check("replay_done", int'(cal_done), 0);
      check("replay_offset", int'(offset), exp_off);
    end
  endtask

  initial begin
    int vals[NS];
    int x;

    reset      = 1'b1;
    cal_start  = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;

    // Reset state
    repeat (3) step();
    check("rst_data", int'(data_out), 0);
    check("rst_valid", int'(data_out_valid), 0);
    check("rst_calmode", int'(cal_mode), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(cal_done), 0);
    check("rst_offset", int'(offset), 0);
    reset = 1'b0;
    step();
    pass(-7);

    // Constant +5
    for (int i = 0; i < NS; i++) vals[i] = 5;
    start_cal();
    feed_cal(vals, 1'b0);
    pass(5);

    // Floor rounding: sum -40 -> -3
    for (int i = 0; i < NS; i++) vals[i] = (i % 2 == 0) ? -3 : -2;
    start_cal();
    feed_cal(vals, 1'b0);
    check("floor_offset", int'(offset), -3);
    pass(250);
    pass(253);

    // Negative saturation with offset +10
    for (int i = 0; i < NS; i++) vals[i] = 10;
    start_cal();
    feed_cal(vals, 1'b0);
    pass(-256);
    pass(-250);

    // Restart at ACCUM sample 9: old offset kept, full count restarts
    start_cal();
    for (int i = 0; i < Settle; i++) send_cal(rnd_sample());
    for (int i = 0; i < 9; i++) send_cal(100);
    start_cal();
    check("restart_offset", int'(offset), exp_off);
    for (int i = 0; i < NS; i++) vals[i] = rnd_sample();
    feed_cal(vals, 1'b0);
    pass(rnd_sample());

    // Reset mid-ACCUM
    start_cal();
    for (int i = 0; i < Settle + 5; i++) send_cal(rnd_sample());
    reset = 1'b1;
    step();
    reset   = 1'b0;
    exp_off = 0;
    check("midrst_offset", int'(offset), 0);
    check("midrst_calmode", int'(cal_mode), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(cal_done), 0);
    check("midrst_valid", int'(data_out_valid), 0);
    pass(rnd_sample());

    // cal_start + data_valid in the same RUN cycle
    for (int i = 0; i < NS; i++) vals[i] = rnd_sample();
    start_cal();
    feed_cal(vals, 1'b0);
    x          = rnd_sample();
    data_in    = WIn'(x);
    data_valid = 1'b1;
    cal_start  = 1'b1;
    step();
    data_valid = 1'b0;
    cal_start  = 1'b0;
    check("simul_valid", int'(data_out_valid), 1);
    check("simul_data", int'(data_out), sat_ref(x, exp_off));
    check("simul_calmode", int'(cal_mode), 1);
    for (int i = 0; i < NS; i++) vals[i] = rnd_sample();
    feed_cal(vals, 1'b0);

    // cal_start during APPLY (with a dropped sample), then the replayed run
    for (int i = 0; i < NS; i++) vals[i] = rnd_sample();
    start_cal();
    feed_cal(vals, 1'b1);
    for (int i = 0; i < NS; i++) vals[i] = rnd_sample();
    feed_cal(vals, 1'b0);
    pass(rnd_sample());

    // Randomized calibrations and pass-through traffic
    for (int it = 0; it < 6; it++) begin
      int base = int'($urandom_range(200)) - 100;
      for (int i = 0; i < NS; i++) vals[i] = base + int'($urandom_range(40)) - 20;
      if (it % 3 == 2) begin
        for (int i = 0; i < NS; i++) vals[i] = rnd_sample();
      end
      start_cal();
      feed_cal(vals, 1'b0);
      for (int k = 0; k < 12; k++) pass(rnd_sample());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
